// File: rtl/tpm_mgmt_pkg.sv
// Shared definitions for the TPM management command path: FSM state encoding,
// locality count and the TPM response codes used by the arbiter.
package tpm_mgmt_pkg;

    localparam int NUM_LOC = 5;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LATCH   = 3'd1;
    localparam logic [2:0] ST_ISSUE   = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_RESPOND = 3'd4;

    localparam logic [31:0] TPM_RC_SUCCESS    = 32'h0000_0000;
    localparam logic [31:0] TPM_RC_FAILURE    = 32'h0000_0101;
    localparam logic [31:0] TPM_RC_INITIALIZE = 32'h0000_0100;
    localparam logic [31:0] TPM_RC_VALUE      = 32'h0000_0084;
    localparam logic [31:0] TPM_RC_AUTH_TYPE  = 32'h0000_0124;

    function automatic logic [2:0] onehot_to_idx(input logic [NUM_LOC-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int n = 0; n < NUM_LOC; n++) begin
            if (oh[n]) idx = idx | 3'(n);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_picker_5.sv
// Combinational round-robin picker: search starts one past last_grant and
// wraps modulo 5; the first requesting locality found is returned one-hot.
module rr_picker_5
    import tpm_mgmt_pkg::*;
(
    input  logic [4:0] req,
    input  logic [2:0] last_grant,
    output logic [4:0] winner
);

    logic       found;
    logic [2:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_LOC; k++) begin
            idx = 3'((32'(last_grant) + 32'(k)) % 32'(NUM_LOC));
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/locality_cmd_arbiter.sv
// Arbitrates TPM commands from five localities onto one management module and
// routes the response back. Optional WAIT watchdog enabled by `define ARB_TIMEOUT_EN.
module locality_cmd_arbiter
    import tpm_mgmt_pkg::*;
#(
    parameter int NUM_LOC        = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_LOC-1:0]      req,
    input  logic [32*NUM_LOC-1:0]   req_cc,
    input  logic [33*NUM_LOC-1:0]   req_param,
    input  logic [31:0]             mm_rc,
    input  logic                    mm_rc_valid,
    output logic [NUM_LOC-1:0]      grant,
    output logic                    mm_start,
    output logic [31:0]             mm_tpm_cc,
    output logic [32:0]             mm_cmd_param,
    output logic [7:0]              mm_locality,
    output logic [NUM_LOC-1:0]      rsp_valid,
    output logic [31:0]             rsp_rc,
    output logic                    busy,
    output logic                    timeout_err
);

    logic [2:0]         state;
    logic [2:0]         last_grant;
    logic [NUM_LOC-1:0] winner;
    logic [31:0]        win_cc;
    logic [32:0]        win_param;
    logic               expire;

    rr_picker_5 u_picker (
        .req        (req),
        .last_grant (last_grant),
        .winner     (winner)
    );

    always_comb begin
        win_cc    = '0;
        win_param = '0;
        for (int n = 0; n < NUM_LOC; n++) begin
            if (winner[n]) begin
                win_cc    = req_cc[32*n +: 32];
                win_param = req_param[33*n +: 33];
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [31:0] wait_cnt;

    assign expire = (state == ST_WAIT) && !mm_rc_valid &&
                    (wait_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 32'd1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign expire             = 1'b0;
    assign unused_timeout_cfg = TIMEOUT_CYCLES[0];
`endif

    // The winner is captured on entry to LATCH so later req/cc/param changes cannot leak in.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            last_grant   <= 3'd4;
            grant        <= '0;
            mm_tpm_cc    <= '0;
            mm_cmd_param <= '0;
            mm_locality  <= '0;
            rsp_rc       <= '0;
            timeout_err  <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state        <= ST_LATCH;
                        grant        <= winner;
                        mm_tpm_cc    <= win_cc;
                        mm_cmd_param <= win_param;
                        mm_locality  <= 8'(winner);
                        last_grant   <= onehot_to_idx(winner);
                    end
                end
                ST_LATCH: begin
                    state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (mm_rc_valid) begin
                        rsp_rc <= mm_rc;
                        state  <= ST_RESPOND;
                    end else begin
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mm_rc_valid) begin
                        rsp_rc <= mm_rc;
                        state  <= ST_RESPOND;
                    end else if (expire) begin
                        rsp_rc      <= TPM_RC_FAILURE;
                        timeout_err <= 1'b1;
                        state       <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    assign mm_start  = (state == ST_ISSUE);
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_RESPOND) ? grant : '0;

endmodule

// File: tb/tb_locality_cmd_arbiter.sv
// Randomized bench for locality_cmd_arbiter against a transaction-level
// round-robin reference model; the watchdog case runs when ARB_TIMEOUT_EN is defined.
module tb_locality_cmd_arbiter;

    localparam int TB_TO = 16;

    logic         clock;
    logic         reset;
    logic [4:0]   req;
    logic [159:0] req_cc;
    logic [164:0] req_param;
    logic [31:0]  mm_rc;
    logic         mm_rc_valid;
    logic [4:0]   grant;
    logic         mm_start;
    logic [31:0]  mm_tpm_cc;
    logic [32:0]  mm_cmd_param;
    logic [7:0]   mm_locality;
    logic [4:0]   rsp_valid;
    logic [31:0]  rsp_rc;
    logic         busy;
    logic         timeout_err;

    int          n_chk;
    int          n_pass;
    int          last_idx;
    logic [31:0] exp_rsp_rc;

    locality_cmd_arbiter #(.NUM_LOC(5), .TIMEOUT_CYCLES(TB_TO)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .req_cc       (req_cc),
        .req_param    (req_param),
        .mm_rc        (mm_rc),
        .mm_rc_valid  (mm_rc_valid),
        .grant        (grant),
        .mm_start     (mm_start),
        .mm_tpm_cc    (mm_tpm_cc),
        .mm_cmd_param (mm_cmd_param),
        .mm_locality  (mm_locality),
        .rsp_valid    (rsp_valid),
        .rsp_rc       (rsp_rc),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    endtask

    // Reference: first requester found scanning upward from one past the previous owner.
    function automatic int pick(input logic [4:0] r, input int last);
        logic [2:0] j;
        for (int k = 1; k <= 5; k++) begin
            j = 3'((last + k) % 5);
            if (r[j]) return int'(j);
        end
        return -1;
    endfunction

    task automatic scramble_cmds();
        logic [63:0] t;
        for (int n = 0; n < 5; n++) begin
            req_cc[32*n +: 32] = $urandom();
            t = {$urandom(), $urandom()};
            req_param[33*n +: 33] = t[32:0];
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        req         = '0;
        mm_rc_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset      = 1'b0;
        last_idx   = 4;
        exp_rsp_rc = '0;
    endtask

    // Entered and left at a negedge with the arbiter idle.
    task automatic run_txn(input logic [4:0] r, input int d, input logic [31:0] rc,
                           input bit drop, input bit noise);
        int          w;
        logic [4:0]  oh;
        logic [31:0] ecc;
        logic [32:0] epar;
        w    = pick(r, last_idx);
        oh   = 5'd1 << w;
        ecc  = req_cc[32*w +: 32];
        epar = req_param[33*w +: 33];
        req  = r;
        @(negedge clock);
        chk("latch_grant", 64'(grant), 64'(oh));
        chk("latch_busy", 64'(busy), 64'd1);
        chk("latch_start", 64'(mm_start), 64'd0);
        chk("latch_loc", 64'(mm_locality), 64'({3'b000, oh}));
        chk("latch_cc", 64'(mm_tpm_cc), 64'(ecc));
        chk("latch_param", 64'(mm_cmd_param), 64'(epar));
        chk("latch_rc_hold", 64'(rsp_rc), 64'(exp_rsp_rc));
        last_idx = w;
        if (drop) req = '0;
        scramble_cmds();
        mm_rc_valid = noise;
        mm_rc       = $urandom();
        @(negedge clock);
        chk("issue_start", 64'(mm_start), 64'd1);
        chk("issue_rsp", 64'(rsp_valid), 64'd0);
        chk("issue_rc_hold", 64'(rsp_rc), 64'(exp_rsp_rc));
        mm_rc_valid = 1'b0;
        for (int i = 0; i < d; i++) begin
            @(negedge clock);
            chk("wait_start", 64'(mm_start), 64'd0);
            chk("wait_rsp", 64'(rsp_valid), 64'd0);
            chk("wait_busy", 64'(busy), 64'd1);
        end
        mm_rc_valid = 1'b1;
        mm_rc       = rc;
        @(negedge clock);
        exp_rsp_rc = rc;
        chk("rsp_valid", 64'(rsp_valid), 64'(oh));
        chk("rsp_rc", 64'(rsp_rc), 64'(rc));
        chk("rsp_cc_held", 64'(mm_tpm_cc), 64'(ecc));
        chk("rsp_param_held", 64'(mm_cmd_param), 64'(epar));
        chk("rsp_timeout", 64'(timeout_err), 64'd0);
        mm_rc_valid = noise;
        mm_rc       = $urandom();
        @(negedge clock);
        mm_rc_valid = 1'b0;
        chk("idle_grant", 64'(grant), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_rsp", 64'(rsp_valid), 64'd0);
        chk("idle_rc_hold", 64'(rsp_rc), 64'(exp_rsp_rc));
    endtask

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        reset       = 1'b1;
        req         = '0;
        req_cc      = '0;
        req_param   = '0;
        mm_rc       = '0;
        mm_rc_valid = 1'b0;
        @(negedge clock);
        do_reset();
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_start", 64'(mm_start), 64'd0);
        chk("rst_rsp", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_timeout", 64'(timeout_err), 64'd0);
        chk("rst_cc", 64'(mm_tpm_cc), 64'd0);
        chk("rst_param", 64'(mm_cmd_param), 64'd0);
        chk("rst_loc", 64'(mm_locality), 64'd0);
        chk("rst_rc", 64'(rsp_rc), 64'd0);

        scramble_cmds();
        req_cc[31:0] = 32'h144;
        run_txn(5'b00001, 3, 32'h0, 1'b0, 1'b0);
        scramble_cmds();
        run_txn(5'b00010, 2, 32'h100, 1'b1, 1'b1);
        scramble_cmds();
        run_txn(5'b01000, 0, 32'h84, 1'b0, 1'b0);

        do_reset();
        for (int t = 0; t < 3; t++) begin
            scramble_cmds();
            run_txn(5'b10101, t, $urandom(), 1'b0, 1'b0);
        end

        // Reset while waiting on the management module.
        req = 5'b01000;
        @(negedge clock);
        @(negedge clock);
        req = '0;
        @(negedge clock);
        @(negedge clock);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("wrst_busy", 64'(busy), 64'd0);
        chk("wrst_grant", 64'(grant), 64'd0);
        chk("wrst_rsp", 64'(rsp_valid), 64'd0);
        chk("wrst_loc", 64'(mm_locality), 64'd0);
        reset       = 1'b0;
        last_idx    = 4;
        exp_rsp_rc  = '0;
        mm_rc_valid = 1'b1;
        mm_rc       = 32'hdead_beef;
        @(negedge clock);
        mm_rc_valid = 1'b0;
        chk("wrst_late_rsp", 64'(rsp_valid), 64'd0);
        chk("wrst_late_busy", 64'(busy), 64'd0);
        chk("wrst_late_rc", 64'(rsp_rc), 64'd0);

`ifdef ARB_TIMEOUT_EN
        begin
            int  steps;
            bit  seen;
            steps = 0;
            seen  = 1'b0;
            req   = 5'b00001;
            @(negedge clock);
            @(negedge clock);
            chk("to_issue", 64'(mm_start), 64'd1);
            req = '0;
            while (!seen && steps < 4 * TB_TO) begin
                @(negedge clock);
                steps++;
                if (timeout_err) seen = 1'b1;
            end
            chk("to_seen", 64'(seen), 64'd1);
            chk("to_latency", 64'(steps), 64'(TB_TO + 1));
            chk("to_rsp", 64'(rsp_valid), 64'd1);
            chk("to_rc", 64'(rsp_rc), 64'h101);
            exp_rsp_rc = 32'h101;
            last_idx   = 0;
            @(negedge clock);
            chk("to_pulse", 64'(timeout_err), 64'd0);
            chk("to_idle", 64'(busy), 64'd0);
        end
`endif

        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                req         = '0;
                mm_rc_valid = 1'($urandom_range(0, 1));
                mm_rc       = $urandom();
                @(negedge clock);
                mm_rc_valid = 1'b0;
                chk("gap_busy", 64'(busy), 64'd0);
                chk("gap_rsp", 64'(rsp_valid), 64'd0);
                chk("gap_rc_hold", 64'(rsp_rc), 64'(exp_rsp_rc));
            end
            scramble_cmds();
            run_txn(5'($urandom_range(1, 31)), int'($urandom_range(0, 6)), $urandom(),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/locality_cmd_arbiter.md
LOCALITY_CMD_ARBITER -- requirements
Module: locality_cmd_arbiter

Interface
REQ-001 Parameter NUM_LOC, 5, number of requesting localities (0..4); fixed at 5.
REQ-002 Parameter TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit in clocks; used only with ARB_TIMEOUT_EN.
REQ-003 Port clock  in  1  system clock; all state changes on rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port req  in  5  per-locality command request level; bit n = locality n.
REQ-006 Port req_cc  in  160  flattened TPM command codes; locality n at [32n+31:32n].
REQ-007 Port req_param  in  165  flattened command parameters; locality n at [33n+32:33n].
REQ-008 Port mm_rc  in  32  response code from management module.
REQ-009 Port mm_rc_valid  in  1  one-cycle strobe qualifying mm_rc.
REQ-010 Port grant  out  5  one-hot owner of the management module; zero when idle.
REQ-011 Port mm_start  out  1  one-cycle command start pulse to management module.
REQ-012 Port mm_tpm_cc  out  32  latched command code of grant owner.
REQ-013 Port mm_cmd_param  out  33  latched parameter of grant owner.
REQ-014 Port mm_locality  out  8  one-hot locality of grant owner, bits 7:5 always 0.
REQ-015 Port rsp_valid  out  5  one-cycle response strobe to the owning locality.
REQ-016 Port rsp_rc  out  32  response code, valid with rsp_valid.
REQ-017 Port busy  out  1  high in every state except IDLE.
REQ-018 Port timeout_err  out  1  one-cycle pulse on watchdog expiry; tied 0 without ARB_TIMEOUT_EN.

Function
REQ-019 FSM states: IDLE, LATCH, ISSUE, WAIT, RESPOND; transitions evaluated each rising edge.
REQ-020 IDLE: any req bit set -> LATCH next cycle; else remain.
REQ-021 Round-robin selection: search starts at last_grant+1 mod 5 and wraps; first set bit wins.
REQ-022 LATCH (1 cycle): grant, mm_tpm_cc, mm_cmd_param, mm_locality, last_grant loaded from winner.
REQ-023 ISSUE (1 cycle): mm_start=1; -> WAIT.
REQ-024 WAIT: hold until mm_rc_valid, then capture mm_rc into rsp_rc -> RESPOND.
REQ-025 mm_rc_valid during ISSUE is accepted as completion -> RESPOND directly.
REQ-026 mm_rc_valid in IDLE, LATCH, RESPOND is ignored.
REQ-027 RESPOND (1 cycle): rsp_valid = grant; -> IDLE; grant clears on entry to IDLE.
REQ-028 Minimum req-to-rsp_valid latency 4 cycles (IDLE, LATCH, ISSUE, RESPOND).
REQ-029 Requester deasserting req after LATCH does not abort; response still strobed.
REQ-030 req/req_cc/req_param changes after LATCH do not affect mm_* outputs.
REQ-031 Requester holding req through RESPOND re-arbitrates; other pending localities win first.
REQ-032 rsp_rc holds last value until next capture.

Reset
REQ-033 On reset: state=IDLE, last_grant=4 (first search starts at locality 0).
REQ-034 On reset: grant, mm_start, rsp_valid, timeout_err, busy = 0; mm_tpm_cc, mm_cmd_param, mm_locality, rsp_rc = 0.
REQ-035 Reset in any state aborts the operation with no rsp_valid pulse.

Configuration
REQ-036 Macro ARB_TIMEOUT_EN defined: 32-bit counter clears in ISSUE and increments in WAIT.
REQ-037 With ARB_TIMEOUT_EN, count reaching TIMEOUT_CYCLES-1 without mm_rc_valid: rsp_rc=32'h00000101 (TPM_RC_FAILURE), timeout_err=1 for one cycle, -> RESPOND.
REQ-038 With ARB_TIMEOUT_EN, mm_rc_valid in the expiry cycle takes precedence; no timeout_err.
REQ-039 Macro undefined: no counter logic; WAIT holds indefinitely; timeout_err tied 0.

Structure
REQ-040 Shared package tpm_mgmt_pkg holds FSM state encoding, NUM_LOC, and TPM_RC_SUCCESS/FAILURE/INITIALIZE/VALUE/AUTH_TYPE constants.
REQ-041 Sub-module rr_picker_5 is combinational: inputs req[4:0] and last_grant[2:0]; output one-hot winner[4:0].

Verification
REQ-042 req=5'b00001, cc=32'h144; mm_rc_valid 3 cycles after mm_start, rc=0 -> mm_locality=8'h01, mm_tpm_cc=32'h144, rsp_valid=5'b00001, rsp_rc=0.
REQ-043 req=5'b10101 held for three transactions from reset -> grant order 00001, 00100, 10000.
REQ-044 mm_rc_valid in ISSUE cycle, rc=32'h84 -> rsp_valid 1 cycle after mm_start (4-cycle latency), rsp_rc=32'h84.
REQ-045 Reset asserted during WAIT -> next cycle IDLE, grant=0, busy=0, no rsp_valid; later mm_rc_valid ignored.
REQ-046 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no mm_rc_valid -> timeout_err and RESPOND, rsp_rc=32'h00000101.
REQ-047 req=5'b00010 dropped after LATCH, then mm_rc_valid with rc=32'h100 -> rsp_valid=5'b00010, rsp_rc=32'h100.
